// File: rtl/pcpi_seg_bridge_if.sv
// Segment-in / PCPI / segment-out bus bundle for pcpi_seg_bridge.
// slave is the bridge's view; master is the pad side plus coprocessor.
interface pcpi_seg_bridge_if #(
  parameter int unsigned SEG_W  = 4,
  parameter int unsigned INSN_W = 32,
  parameter int unsigned RD_W   = 32
);
  logic [SEG_W-1:0]  seg_in;
  logic              seg_valid;
  logic              seg_ready;
  logic              pcpi_valid;
  logic [INSN_W-1:0] pcpi_insn;
  logic              pcpi_ready;
  logic              pcpi_wr;
  logic              pcpi_wait;
  logic [RD_W-1:0]   pcpi_rd;
  logic [SEG_W-1:0]  res_seg;
  logic              res_valid;
  logic              res_ready;
  logic              busy;
  logic              timeout_err;

  modport slave (
    input  seg_in, seg_valid, pcpi_ready, pcpi_wr, pcpi_wait, pcpi_rd, res_ready,
    output seg_ready, pcpi_valid, pcpi_insn, res_seg, res_valid, busy, timeout_err
  );

  modport master (
    output seg_in, seg_valid, pcpi_ready, pcpi_wr, pcpi_wait, pcpi_rd, res_ready,
    input  seg_ready, pcpi_valid, pcpi_insn, res_seg, res_valid, busy, timeout_err
  );
endinterface

// File: rtl/pcpi_seg_bridge.sv
// Segmented PCPI front end: assembles an instruction from narrow segments,
// issues it with a timeout, and streams the result back LSB segment first.
module pcpi_seg_bridge #(
  parameter int unsigned SEG_W   = 4,
  parameter int unsigned INSN_W  = 32,
  parameter int unsigned RD_W    = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input logic              clk,
  input logic              rst_n,
  pcpi_seg_bridge_if.slave bus
);
  localparam int unsigned NSEG = INSN_W / SEG_W;
  localparam int unsigned NRES = RD_W / SEG_W;
  localparam int unsigned SC_W = (NSEG > 1) ? $clog2(NSEG) : 1;
  localparam int unsigned RC_W = (NRES > 1) ? $clog2(NRES) : 1;
  localparam int unsigned TO_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {S_LOAD, S_ISSUE, S_DRAIN} state_e;

  state_e            state_q, state_d;
  logic [SC_W-1:0]   seg_cnt_q, seg_cnt_d;
  logic [RC_W-1:0]   res_cnt_q, res_cnt_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic [INSN_W-1:0] insn_q, insn_d;
  logic [RD_W-1:0]   shift_q, shift_d;
  logic              err_q, err_d;
  logic              pcpi_valid_q, pcpi_valid_d;
  logic              res_valid_q, res_valid_d;
  logic              busy_q, busy_d;
  logic              seg_ready_q, seg_ready_d;
  logic [TO_W-1:0]   to_inc;

  assign to_inc = to_cnt_q + TO_W'(1);

  // Next-state and datapath; output flags are registered copies of state_d.
  always_comb begin
    state_d   = state_q;
    seg_cnt_d = seg_cnt_q;
    res_cnt_d = res_cnt_q;
    to_cnt_d  = to_cnt_q;
    insn_d    = insn_q;
    shift_d   = shift_q;
    err_d     = err_q;
    case (state_q)
      S_LOAD: begin
        if (bus.seg_valid && seg_ready_q) begin
          insn_d[SEG_W*int'(seg_cnt_q) +: SEG_W] = bus.seg_in;
          if (seg_cnt_q == '0) err_d = 1'b0;
          if (seg_cnt_q == SC_W'(NSEG - 1)) begin
            seg_cnt_d = '0;
            to_cnt_d  = '0;
            state_d   = S_ISSUE;
          end else begin
            seg_cnt_d = seg_cnt_q + SC_W'(1);
          end
        end
      end
      S_ISSUE: begin
        if (bus.pcpi_ready) begin
          if (bus.pcpi_wr) begin
            shift_d   = bus.pcpi_rd;
            res_cnt_d = '0;
            state_d   = S_DRAIN;
          end else begin
            state_d = S_LOAD;
          end
        end else if (!bus.pcpi_wait && (TIMEOUT != 0)) begin
          // Ready takes precedence over expiry, hence the else-chain.
          if (to_inc == TO_W'(TIMEOUT)) begin
            err_d   = 1'b1;
            state_d = S_LOAD;
          end else begin
            to_cnt_d = to_inc;
          end
        end
      end
      S_DRAIN: begin
        if (res_valid_q && bus.res_ready) begin
          shift_d = shift_q >> SEG_W;
          if (res_cnt_q == RC_W'(NRES - 1)) begin
            res_cnt_d = '0;
            state_d   = S_LOAD;
          end else begin
            res_cnt_d = res_cnt_q + RC_W'(1);
          end
        end
      end
      default: state_d = S_LOAD;
    endcase
    pcpi_valid_d = (state_d == S_ISSUE);
    res_valid_d  = (state_d == S_DRAIN);
    busy_d       = (state_d == S_ISSUE) || (state_d == S_DRAIN);
    seg_ready_d  = (state_d == S_LOAD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_LOAD;
      seg_cnt_q    <= '0;
      res_cnt_q    <= '0;
      to_cnt_q     <= '0;
      insn_q       <= '0;
      shift_q      <= '0;
      err_q        <= 1'b0;
      pcpi_valid_q <= 1'b0;
      res_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      seg_ready_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      seg_cnt_q    <= seg_cnt_d;
      res_cnt_q    <= res_cnt_d;
      to_cnt_q     <= to_cnt_d;
      insn_q       <= insn_d;
      shift_q      <= shift_d;
      err_q        <= err_d;
      pcpi_valid_q <= pcpi_valid_d;
      res_valid_q  <= res_valid_d;
      busy_q       <= busy_d;
      seg_ready_q  <= seg_ready_d;
    end
  end

  assign bus.seg_ready   = seg_ready_q;
  assign bus.pcpi_valid  = pcpi_valid_q;
  assign bus.pcpi_insn   = insn_q;
  assign bus.res_seg     = shift_q[SEG_W-1:0];
  assign bus.res_valid   = res_valid_q;
  assign bus.busy        = busy_q;
  assign bus.timeout_err = err_q;
endmodule

// File: tb/tb_pcpi_seg_bridge.sv
// Scenario bench for pcpi_seg_bridge with a result-segment scoreboard.
module tb_pcpi_seg_bridge;
  localparam int unsigned SEG_W   = 4;
  localparam int unsigned INSN_W  = 32;
  localparam int unsigned RD_W    = 32;
  localparam int unsigned TIMEOUT = 8;
  localparam int unsigned NSEG    = INSN_W / SEG_W;
  localparam int unsigned NRES    = RD_W / SEG_W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int errors = 0;
  int checks = 0;
  logic [SEG_W-1:0] exp_q[$];

  pcpi_seg_bridge_if #(.SEG_W(SEG_W), .INSN_W(INSN_W), .RD_W(RD_W)) bus ();

  pcpi_seg_bridge #(.SEG_W(SEG_W), .INSN_W(INSN_W), .RD_W(RD_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic load_word(input logic [INSN_W-1:0] w, input int first);
    for (int k = first; k < NSEG; k++) begin
      @(negedge clk);
      checks++; if (bus.seg_ready !== 1'b1) begin errors++; $display("FAIL load_seg_ready[%0d]: got %b want 1", k, bus.seg_ready); end
      if (k == NSEG - 1) begin
        checks++; if (bus.pcpi_valid !== 1'b0) begin errors++; $display("FAIL load_valid_early: got %b want 0", bus.pcpi_valid); end
      end
      bus.seg_valid = 1'b1;
      bus.seg_in    = w[SEG_W*k +: SEG_W];
    end
    @(negedge clk);
    bus.seg_valid = 1'b0;
    checks++; if (bus.pcpi_valid !== 1'b1) begin errors++; $display("FAIL load_valid: got %b want 1", bus.pcpi_valid); end
    checks++; if (bus.pcpi_insn !== w) begin errors++; $display("FAIL load_insn: got %h want %h", bus.pcpi_insn, w); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL load_busy: got %b want 1", bus.busy); end
    checks++; if (bus.seg_ready !== 1'b0) begin errors++; $display("FAIL load_seg_ready_issue: got %b want 0", bus.seg_ready); end
  endtask

  task automatic complete(input bit wr, input logic [RD_W-1:0] rd);
    bus.pcpi_ready = 1'b1;
    bus.pcpi_wr    = wr;
    bus.pcpi_rd    = rd;
    if (wr) for (int k = 0; k < NRES; k++) exp_q.push_back(rd[SEG_W*k +: SEG_W]);
    @(negedge clk);
    bus.pcpi_ready = 1'b0;
    bus.pcpi_wr    = 1'b0;
    checks++; if (bus.pcpi_valid !== 1'b0) begin errors++; $display("FAIL done_valid: got %b want 0", bus.pcpi_valid); end
    checks++; if (bus.res_valid !== wr) begin errors++; $display("FAIL done_res_valid: got %b want %b", bus.res_valid, wr); end
    checks++; if (bus.busy !== wr) begin errors++; $display("FAIL done_busy: got %b want %b", bus.busy, wr); end
    checks++; if (bus.seg_ready !== !wr) begin errors++; $display("FAIL done_seg_ready: got %b want %b", bus.seg_ready, !wr); end
  endtask

  task automatic drain(input bit bp, input bit junk);
    int cyc;
    int ph;
    bit stalled;
    bit rr;
    logic [SEG_W-1:0] held;
    logic [SEG_W-1:0] exp;
    cyc = 0; ph = 0; stalled = 1'b0; held = '0;
    while (exp_q.size() > 0) begin
      if (cyc >= 100) begin
        checks++; errors++;
        $display("FAIL drain_bound: %0d segments still pending after %0d cycles", exp_q.size(), cyc);
        exp_q.delete();
        break;
      end
      checks++; if (bus.res_valid !== 1'b1) begin errors++; $display("FAIL drain_res_valid: got %b want 1", bus.res_valid); end
      if (stalled) begin
        checks++; if (bus.res_seg !== held) begin errors++; $display("FAIL drain_stable: got %h want %h", bus.res_seg, held); end
      end
      rr = bp ? (ph % 3 == 0) : 1'b1;
      ph++;
      bus.res_ready = rr;
      if (junk) begin
        bus.seg_valid = 1'b1;
        bus.seg_in    = SEG_W'($urandom);
      end
      if (rr) begin
        exp = exp_q.pop_front();
        checks++; if (bus.res_seg !== exp) begin errors++; $display("FAIL drain_seg: got %h want %h", bus.res_seg, exp); end
        stalled = 1'b0;
      end else begin
        held    = bus.res_seg;
        stalled = 1'b1;
      end
      @(negedge clk);
      cyc++;
    end
    bus.res_ready = 1'b0;
    bus.seg_valid = 1'b0;
    checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL drain_end_valid: got %b want 0", bus.res_valid); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL drain_end_busy: got %b want 0", bus.busy); end
    checks++; if (bus.seg_ready !== 1'b1) begin errors++; $display("FAIL drain_end_seg_ready: got %b want 1", bus.seg_ready); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++; if (bus.pcpi_valid !== 1'b0) begin errors++; $display("FAIL rst_pcpi_valid: got %b want 0", bus.pcpi_valid); end
    checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL rst_res_valid: got %b want 0", bus.res_valid); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
    checks++; if (bus.timeout_err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", bus.timeout_err); end
    checks++; if (bus.pcpi_insn !== '0) begin errors++; $display("FAIL rst_insn: got %h want 0", bus.pcpi_insn); end
    checks++; if (bus.res_seg !== '0) begin errors++; $display("FAIL rst_res_seg: got %h want 0", bus.res_seg); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (bus.seg_ready !== 1'b1) begin errors++; $display("FAIL rst_seg_ready: got %b want 1", bus.seg_ready); end
  endtask

  task automatic test_load_result();
    load_word(32'h0123_4567, 0);
    repeat (2) @(negedge clk);
    complete(1'b1, 32'hDEAD_BEEF);
    drain(1'b0, 1'b0);
  endtask

  task automatic test_timeout();
    int cnt;
    load_word(32'hCAFE_F00D, 0);
    cnt = 0;
    while (bus.pcpi_valid === 1'b1 && cnt < 50) begin
      cnt++;
      @(negedge clk);
    end
    checks++; if (cnt != int'(TIMEOUT)) begin errors++; $display("FAIL to_valid_cycles: got %0d want %0d", cnt, TIMEOUT); end
    checks++; if (bus.timeout_err !== 1'b1) begin errors++; $display("FAIL to_err_set: got %b want 1", bus.timeout_err); end
    checks++; if (bus.seg_ready !== 1'b1) begin errors++; $display("FAIL to_seg_ready: got %b want 1", bus.seg_ready); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL to_busy: got %b want 0", bus.busy); end
    bus.seg_valid = 1'b1;
    bus.seg_in    = 4'h3;
    @(negedge clk);
    bus.seg_valid = 1'b0;
    checks++; if (bus.timeout_err !== 1'b0) begin errors++; $display("FAIL to_err_clear: got %b want 0", bus.timeout_err); end
    load_word(32'h1357_9BD3, 1);
    complete(1'b0, '0);
  endtask

  task automatic test_wait();
    load_word(32'h0F0F_0F0F, 0);
    bus.pcpi_wait = 1'b1;
    repeat (20) @(negedge clk);
    checks++; if (bus.pcpi_valid !== 1'b1) begin errors++; $display("FAIL wait_valid: got %b want 1", bus.pcpi_valid); end
    checks++; if (bus.timeout_err !== 1'b0) begin errors++; $display("FAIL wait_err_mid: got %b want 0", bus.timeout_err); end
    bus.pcpi_wait = 1'b0;
    complete(1'b1, 32'h0000_0005);
    drain(1'b0, 1'b0);
    checks++; if (bus.timeout_err !== 1'b0) begin errors++; $display("FAIL wait_err_end: got %b want 0", bus.timeout_err); end
  endtask

  task automatic test_no_write();
    load_word(32'h0000_0001, 0);
    complete(1'b0, 32'hFFFF_FFFF);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL nowr_res_valid[%0d]: got %b want 0", i, bus.res_valid); end
    end
  endtask

  task automatic test_back_to_back();
    load_word(32'h600D_CAFE, 0);
    complete(1'b1, 32'h7654_3210);
    drain(1'b1, 1'b1);
    checks++; if (bus.pcpi_insn !== 32'h600D_CAFE) begin errors++; $display("FAIL bp_insn_kept: got %h want 600dcafe", bus.pcpi_insn); end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      bus.seg_valid = 1'b1;
      bus.seg_in    = SEG_W'(k + 9);
    end
    @(negedge clk);
    bus.seg_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.pcpi_insn !== '0) begin errors++; $display("FAIL rmid_load_insn: got %h want 0", bus.pcpi_insn); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rmid_load_busy: got %b want 0", bus.busy); end
    @(negedge clk);
    rst_n = 1'b1;
    load_word(32'hA1B2_C3D4, 0);
    complete(1'b1, 32'h1234_5678);
    bus.res_ready = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    exp_q.delete();
    checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL rmid_drain_res_valid: got %b want 0", bus.res_valid); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rmid_drain_busy: got %b want 0", bus.busy); end
    checks++; if (bus.res_seg !== '0) begin errors++; $display("FAIL rmid_drain_res_seg: got %h want 0", bus.res_seg); end
    checks++; if (bus.pcpi_valid !== 1'b0) begin errors++; $display("FAIL rmid_drain_pcpi_valid: got %b want 0", bus.pcpi_valid); end
    @(negedge clk);
    rst_n = 1'b1;
    load_word(32'h89AB_CDEF, 0);
    complete(1'b0, '0);
  endtask

  initial begin
    bus.seg_in     = '0;
    bus.seg_valid  = 1'b0;
    bus.pcpi_ready = 1'b0;
    bus.pcpi_wr    = 1'b0;
    bus.pcpi_wait  = 1'b0;
    bus.pcpi_rd    = '0;
    bus.res_ready  = 1'b0;
    test_reset();
    test_load_result();
    test_timeout();
    test_wait();
    test_no_write();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pcpi_seg_bridge.md
Name: pcpi_seg_bridge

Overview:
- Parametrised successor to the nibble-loader/PCPI front end in the TinyTapeout top.
- Assembles a PCPI instruction word from narrow segments delivered over a valid/ready port.
- Issues the word to a PCPI coprocessor with a full valid/ready/wait handshake and a programmable timeout.
- Returns the coprocessor result as segments over a second valid/ready port. Sits between the pad-level ui_in/uo_out pins and the PCPI unit.

Parameters:
- SEG_W, 4, segment width in bits, both directions.
- INSN_W, 32, instruction width; must be a multiple of SEG_W; NSEG = INSN_W/SEG_W.
- RD_W, 32, result width; must be a multiple of SEG_W; NRES = RD_W/SEG_W.
- TIMEOUT, 255, maximum non-wait ISSUE cycles before abort; 0 disables the timeout.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- seg_in  in  SEG_W  instruction segment.
- seg_valid  in  1  seg_in valid.
- seg_ready  out  1  bridge accepts a segment.
- pcpi_valid  out  1  instruction valid to coprocessor.
- pcpi_insn  out  INSN_W  assembled instruction.
- pcpi_ready  in  1  coprocessor done.
- pcpi_wr  in  1  coprocessor result valid, qualified by pcpi_ready.
- pcpi_wait  in  1  coprocessor busy; suspends the timeout.
- pcpi_rd  in  RD_W  coprocessor result.
- res_seg  out  SEG_W  result segment.
- res_valid  out  1  res_seg valid.
- res_ready  in  1  sink accepts res_seg.
- busy  out  1  high in ISSUE or DRAIN.
- timeout_err  out  1  sticky abort flag.

Behaviour:
- Clock is clk; reset is asynchronous and active-low on rst_n. All outputs are registered or derived from registered state.
- Reset values: state=LOAD, seg count=0, result count=0, pcpi_insn=0, pcpi_valid=0, res_seg=0, res_valid=0, timeout_err=0, busy=0. seg_ready=1 once reset is released.
- States: LOAD, ISSUE, DRAIN.
- LOAD:
  - seg_ready=1.
  - A transfer occurs when seg_valid && seg_ready. Segment k (0-based, in arrival order) is written to pcpi_insn[SEG_W*k +: SEG_W], so the first segment lands in the LSBs.
  - Accepting segment 0 clears timeout_err.
  - Accepting segment NSEG-1 moves to ISSUE, clears the seg count, and sets pcpi_valid=1 from the next cycle.
  - No gap cycles are required between segments.
- ISSUE:
  - seg_ready=0. pcpi_insn is held stable and pcpi_valid=1.
  - Timeout counter is cleared on entry. It increments on each ISSUE cycle with pcpi_ready=0 and pcpi_wait=0, and holds while pcpi_wait=1.
  - pcpi_ready=1 with pcpi_wr=1: latch pcpi_rd into the result shift register and go to DRAIN.
  - pcpi_ready=1 with pcpi_wr=0: go to LOAD; no result is returned.
  - In both cases pcpi_valid falls on the next edge.
  - If TIMEOUT!=0 and the counter would reach TIMEOUT with pcpi_ready still 0: set timeout_err=1, drop pcpi_valid, go to LOAD. pcpi_valid is therefore high for exactly TIMEOUT non-wait cycles.
  - pcpi_ready=1 on the same cycle as timeout expiry: ready wins and there is no error.
- DRAIN:
  - res_valid=1 and res_seg = shift register [SEG_W-1:0], LSB segment first.
  - On res_valid && res_ready, shift right by SEG_W and increment the result count.
  - After segment NRES-1 transfers, res_valid falls and the state returns to LOAD.
  - res_seg is held stable while res_ready=0.
  - seg_ready=0 throughout DRAIN; new segments are back-pressured.
- busy = (state==ISSUE) || (state==DRAIN).
- Reset mid-operation, in any state: pcpi_valid, res_valid and busy drop immediately (asynchronously). The partial instruction and partial result are discarded; the next cycle after reset release starts at segment 0.
- Counters are sized $clog2(NSEG), $clog2(NRES) and $clog2(TIMEOUT+1), minimum 1 bit each. There is no wrap-around in normal flow because the counts reset at the terminal value.

Test Plan:
- Load and result: SEG_W=4, INSN_W=32. Send 7,6,5,4,3,2,1,0 back-to-back → pcpi_insn=0x01234567 and pcpi_valid rises the cycle after the 8th accept. Model returns ready+wr after 3 cycles with rd=0xDEADBEEF → res_seg sequence F,E,E,B,D,A,E,D, then state is LOAD.
- Timeout: TIMEOUT=8, coprocessor silent with wait=0 → pcpi_valid high exactly 8 cycles, timeout_err=1, seg_ready=1. The next segment accept clears timeout_err.
- Wait suspends timeout: TIMEOUT=8, pcpi_wait=1 for 20 cycles, then ready+wr with rd=0x5 → no timeout_err and result 5,0,0,0,0,0,0,0.
- No-write completion: ready with wr=0 → no res_valid, back to LOAD, busy falls the next cycle.
- Result back-pressure: res_ready toggles 1,0,0,1,... → each segment appears exactly once, res_seg is stable while stalled, and seg_valid is ignored during DRAIN.
- Reset mid-run: rst_n low after 5 segments, and again during DRAIN → outputs reach reset values immediately. A fresh 8-segment load then produces the correct pcpi_insn.
